// File: rtl/mmio_bus_ctrl.sv
// Memory / memory-mapped I/O bus controller: decodes core accesses, sequences memory
// wait states and device handshakes, and returns read data with a one-cycle ack.
module mmio_bus_ctrl #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned NUM_IO      = 4,
    parameter int unsigned IDX_W       = 2,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned IO_TIMEOUT  = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ADDR_W-1:0]        cpu_adr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic                     cpu_ack,
    output logic                     cpu_err,
    output logic                     cpu_busy,
    output logic                     mem_en,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_adr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [NUM_IO-1:0]        io_sel,
    output logic                     io_we,
    output logic [ADDR_W-1:0]        io_adr,
    output logic [DATA_W-1:0]        io_wdata,
    input  logic [NUM_IO*DATA_W-1:0] io_rdata,
    input  logic [NUM_IO-1:0]        io_ready
);

    localparam int unsigned CNT_MAX = (MEM_LATENCY > IO_TIMEOUT) ? MEM_LATENCY : IO_TIMEOUT;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] IO_LAST  = CNT_W'(IO_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM,
        S_IO,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NUM_IO-1:0]   dev_q, dev_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [NUM_IO-1:0]   io_sel_q, io_sel_d;
    logic                io_we_q, io_we_d;

    logic [IDX_W-1:0]    req_idx;
    logic                req_io;
    logic [NUM_IO-1:0]   req_sel;
    logic                req_ok;
    logic                cur_ready;
    logic [DATA_W-1:0]   cur_rdata;

    assign req_idx = cpu_adr[ADDR_W-3 -: IDX_W];
    assign req_io  = &cpu_adr[ADDR_W-1 -: 2];
    assign req_ok  = |req_sel;

    // An index with no matching select bit is out of range and is rejected.
    always_comb begin
        req_sel = '0;
        for (int unsigned i = 0; i < NUM_IO; i++) begin
            req_sel[i] = (req_idx == IDX_W'(i));
        end
    end

    always_comb begin
        cur_ready = 1'b0;
        cur_rdata = '0;
        for (int unsigned i = 0; i < NUM_IO; i++) begin
            if (dev_q[i]) begin
                cur_ready = io_ready[i];
                cur_rdata = io_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        adr_d       = adr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        dev_d       = dev_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        mem_en_d    = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        io_sel_d    = '0;
        io_we_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    adr_d   = cpu_adr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    dev_d   = req_sel;
                    cnt_d   = '0;
                    if (req_io && !req_ok) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (req_io) begin
                        state_d  = S_IO;
                        io_sel_d = req_sel;
                        io_we_d  = cpu_we;
                    end else begin
                        state_d     = S_MEM;
                        mem_en_d    = 1'b1;
                        mem_read_d  = !cpu_we;
                        mem_write_d = cpu_we;
                    end
                end
            end
            S_MEM: begin
                if (cnt_q == MEM_LAST) begin
                    state_d = S_RESP;
                    rdata_d = we_q ? '0 : mem_rdata;
                    err_d   = 1'b0;
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    mem_en_d   = 1'b1;
                    mem_read_d = !we_q;
                end
            end
            S_IO: begin
                // Ready is checked before the timeout so a late response still wins.
                if (cur_ready) begin
                    state_d = S_RESP;
                    rdata_d = we_q ? '0 : cur_rdata;
                    err_d   = 1'b0;
                end else if (cnt_q == IO_LAST) begin
                    state_d = S_RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    io_sel_d = dev_q;
                    io_we_d  = we_q;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            adr_q       <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            dev_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            io_sel_q    <= '0;
            io_we_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            adr_q       <= adr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            dev_q       <= dev_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            mem_en_q    <= mem_en_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            io_sel_q    <= io_sel_d;
            io_we_q     <= io_we_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_err   = err_q;
    assign cpu_ack   = (state_q == S_RESP);
    assign cpu_busy  = (state_q != S_IDLE);
    assign mem_en    = mem_en_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_adr   = adr_q;
    assign mem_wdata = wdata_q;
    assign io_sel    = io_sel_q;
    assign io_we     = io_we_q;
    assign io_adr    = adr_q;
    assign io_wdata  = wdata_q;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Randomised bench for mmio_bus_ctrl against a transaction-level model of the bus protocol.
module tb_mmio_bus_ctrl;

    localparam int unsigned NIO = 3;
    localparam int unsigned LAT = 2;
    localparam int unsigned TMO = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_adr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_err;
    logic        cpu_busy;
    logic        mem_en;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_adr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic [2:0]  io_sel;
    logic        io_we;
    logic [15:0] io_adr;
    logic [15:0] io_wdata;
    logic [47:0] io_rdata = '0;
    logic [2:0]  io_ready = '0;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    mmio_bus_ctrl #(
        .DATA_W      (16),
        .ADDR_W      (16),
        .NUM_IO      (NIO),
        .IDX_W       (2),
        .MEM_LATENCY (LAT),
        .IO_TIMEOUT  (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_adr   (cpu_adr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_err   (cpu_err),
        .cpu_busy  (cpu_busy),
        .mem_en    (mem_en),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .io_sel    (io_sel),
        .io_we     (io_we),
        .io_adr    (io_adr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .io_ready  (io_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {busy, mem_en, mem_read, mem_write, io_we, ack, err, io_sel[2:0]}
    function automatic logic [9:0] status();
        return {cpu_busy, mem_en, mem_read, mem_write, io_we, cpu_ack, cpu_err, io_sel};
    endfunction

    task automatic check_all_zero(input string tag);
        check(tag, 32'(status()), 32'(0));
        check({tag, "_rdata"}, 32'(cpu_rdata), 32'(0));
        check({tag, "_madr"}, 32'({mem_adr, mem_wdata}), 32'(0));
        check({tag, "_iadr"}, 32'({io_adr, io_wdata}), 32'(0));
    endtask

    task automatic idle_gap(input int unsigned k);
        cpu_req = 1'b0;
        repeat (k) begin
            @(posedge clk);
            @(negedge clk);
            check("gap_status", 32'(status()), 32'(0));
        end
    endtask

    // One access: dly is the IO cycle in which the addressed device raises ready.
    task automatic access(input logic [15:0] adr, input logic we, input logic [15:0] wd,
                          input int unsigned dly, input bit hold);
        bit          is_io;
        bit          bad;
        bit          exp_err;
        int unsigned idx;
        int unsigned span;
        logic [2:0]  sel;
        logic [15:0] exp_rd;
        logic [9:0]  exp_st;

        @(posedge clk);
        @(negedge clk);
        check("idle_status", 32'(status()), 32'(0));
        check("idle_rdata", 32'(cpu_rdata), 32'(0));

        cpu_req   = 1'b1;
        cpu_adr   = adr;
        cpu_we    = we;
        cpu_wdata = wd;
        io_ready  = '0;
        mem_rdata = 16'($urandom);

        is_io   = (adr[15:14] == 2'b11);
        idx     = 32'(adr[13:12]);
        bad     = is_io && (idx >= NIO);
        sel     = (is_io && !bad) ? 3'(1 << idx) : 3'b000;
        span    = bad ? 0 : (is_io ? ((dly < TMO) ? dly : TMO) : LAT);
        exp_err = bad || (is_io && dly > TMO);
        exp_rd  = '0;

        for (int unsigned n = 1; n <= span + 1; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n <= span) begin
                if (is_io)
                    exp_st = {1'b1, 1'b0, 1'b0, 1'b0, we, 1'b0, 1'b0, sel};
                else
                    exp_st = {1'b1, 1'b1, !we, (we && n == 1), 1'b0, 1'b0, 1'b0, 3'b000};
            end else begin
                exp_st = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_err, 3'b000};
            end
            check("cycle_status", 32'(status()), 32'(exp_st));
            if (n <= span) begin
                if (is_io) check("io_adr_data", 32'({io_adr, io_wdata}), 32'({adr, wd}));
                else       check("mem_adr_data", 32'({mem_adr, mem_wdata}), 32'({adr, wd}));
            end else begin
                check("ack_rdata", 32'(cpu_rdata), 32'((we || exp_err) ? 16'h0000 : exp_rd));
            end

            cpu_req = hold;
            if (hold) begin
                cpu_adr   = 16'($urandom);
                cpu_we    = 1'($urandom);
                cpu_wdata = 16'($urandom);
            end
            mem_rdata = 16'($urandom);
            io_rdata  = {16'($urandom), 32'($urandom)};
            io_ready  = 3'($urandom) & ~sel;
            if (is_io && n == dly) io_ready = io_ready | sel;
            if (n == span && !is_io) exp_rd = mem_rdata;
            if (n == span && is_io && !bad) exp_rd = io_rdata[idx*16 +: 16];
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        access(16'h0010, 1'b0, 16'h0000, 0, 1'b0);
        access(16'h3FFE, 1'b1, 16'h1234, 0, 1'b0);
        access(16'hC000, 1'b0, 16'h0000, 3, 1'b0);
        access(16'hE000, 1'b0, 16'h0000, 99, 1'b0);
        access(16'hF000, 1'b0, 16'h0000, 1, 1'b0);
        access(16'hD004, 1'b1, 16'hA5A5, TMO, 1'b1);
        access(16'hE124, 1'b0, 16'h0000, TMO + 1, 1'b1);
        access(16'h8000, 1'b1, 16'h5A5A, 0, 1'b1);
        idle_gap(2);

        // Reset in the middle of an I/O wait
        @(posedge clk);
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_adr  = 16'hD123;
        cpu_we   = 1'b0;
        io_ready = '0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_reset_sel", 32'(status()), 32'({1'b1, 6'b000000, 3'b010}));
        #2 rst = 1'b0;
        #1 check_all_zero("async_reset");
        cpu_req = 1'b0;
        @(negedge clk);
        check_all_zero("held_reset");
        rst = 1'b1;
        access(16'hD123, 1'b0, 16'h0000, 2, 1'b0);

        for (int unsigned t = 0; t < 300; t++) begin
            logic [15:0] a;
            a = 16'($urandom);
            if ($urandom_range(0, 1) == 1) a[15:14] = 2'b11;
            access(a, 1'($urandom), 16'($urandom), $urandom_range(1, TMO + 2), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
